multicycle_alu: RTL and testbench
=================================

Name: multicycle_alu

Overview:
- Execution unit that consumes the 4-bit operation code produced by the ALU control decoder.
- Supported operations: add, sub, mult, division, move, swap and do-nothing.
- Add, sub, move, swap and do-nothing complete in one cycle. Mult (shift-add) and division (restoring) iterate one bit per cycle under a start/busy/done handshake.
- Sits in the execute stage; the controller holds off the next op until done.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- operation  input  4  op code: 0000 add, 0001 sub, 0010 mult, 0011 division, 0100 move, 0101 swap, 1111 do nothing; others treated as 1111.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- result  output  WIDTH  primary result, registered.
- result_hi  output  WIDTH  secondary result, registered.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- div_by_zero  output  1  set on completion of division with b==0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on rst. rst dominates start, including mid-operation.
- On reset: state=IDLE, counter=0. result, result_hi, busy, done, div_by_zero (and flags if present) all 0. Any in-flight op is abandoned, with no done.
- States: IDLE, MUL, DIV, DONE.
- Accept: start=1 while in IDLE. a, b and operation are latched on the accepting edge; later input changes are ignored. start is ignored in MUL, DIV and DONE (no queueing).
- IDLE -> DONE when the op is add, sub, move, swap, do nothing, or division with b==0.
- IDLE -> MUL on mult; IDLE -> DIV on division with b!=0. The counter loads 0 on entry.
- MUL/DIV: one iteration per cycle. After WIDTH iterations (counter==WIDTH-1 on the final edge) -> DONE.
- DONE: done=1, busy=1 for exactly one cycle, then -> IDLE. A new start is accepted no earlier than the cycle after DONE.
- Latency from accept edge to done-high cycle: 1 cycle for single-cycle ops; WIDTH+1 cycles for mult/div with b!=0. Single-cycle throughput is one op per 2 cycles.
- Results are written on the edge entering DONE and held until the next completion or reset:
  - add: result=(a+b) mod 2^WIDTH; result_hi unchanged.
  - sub: result=(a-b) mod 2^WIDTH; result_hi unchanged.
  - mult: {result_hi,result} = full 2*WIDTH-bit product.
  - division, b!=0: result=quotient, result_hi=remainder.
  - division, b==0: result=all ones, result_hi=a, div_by_zero=1.
  - move: result=a; result_hi unchanged.
  - swap: result=b, result_hi=a.
  - do nothing / undefined: result and result_hi unchanged; done still pulses.
- div_by_zero is rewritten at every completion: 1 only for division by zero, else 0.
- Internal mult/div datapath registers are not visible at the outputs until DONE.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- With it defined, two extra outputs, both registered, updated only at completion, and reset to 0:
  - zero_flag (1): 1 when the new result==0.
  - carry_flag (1): carry-out for add; borrow (a<b) for sub; 0 for all other ops.
- Without it: the ports and the logic are absent; all other behaviour is identical.

Test Plan:
- add a=0xFFFF, b=0x0001 -> result=0x0000, done exactly 1 cycle after accept, busy high that cycle only. With ALU_FLAGS_EN: zero_flag=1, carry_flag=1.
- mult a=0x1234, b=0x0100 -> done at cycle 17 after accept, result=0x3400, result_hi=0x0012. start pulses during busy are ignored; result unchanged until done.
- division a=100, b=7 -> result=0x000E, result_hi=0x0002, div_by_zero=0, done at cycle 17. Repeat with b=0 -> done at cycle 1, result=0xFFFF, result_hi=0x0064, div_by_zero=1.
- swap a=0xAAAA, b=0x5555 -> result=0x5555, result_hi=0xAAAA. Then operation=4'b1001 -> done pulses, outputs unchanged.
- Start division a=0xFFFF, b=3; assert rst at cycle 5 -> next cycle: busy=0, done=0, all outputs 0, no done afterwards. A new add 2+3 accepted after reset -> result=5.
- Back-to-back: start held high continuously with sub a=5, b=7 -> accepts every second cycle, result=0xFFFE. With ALU_FLAGS_EN: carry_flag=1.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multi-cycle execute-stage ALU: single-cycle add/sub/move/swap/nop, plus
// iterative shift-add multiply and restoring divide (one bit per cycle).
// Optional zero/carry flag outputs are enabled with the ALU_FLAGS_EN macro.
module multicycle_alu #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero_flag,
    output logic             carry_flag
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_MOVE = 4'b0100;
    localparam logic [3:0] OP_SWAP = 4'b0101;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             last;

    // Iteration datapath: opnd is the multiplicand or divisor; work_hi/work_lo
    // hold partial product / remainder and multiplier / quotient.
    logic [WIDTH-1:0] opnd, work_hi, work_lo;
    logic [WIDTH:0]   mul_sum, div_sh;
    logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;
    logic             div_ge;

    // Completion write-back strobe and values
    logic             wr;
    logic [WIDTH-1:0] res_n, hi_n;
    logic             dbz_n;

    assign last = (cnt == CNT_LAST);

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (operation == OP_MUL)
                        state_n = S_MUL;
                    else if (operation == OP_DIV && b != '0)
                        state_n = S_DIV;
                    else
                        state_n = S_DONE;
                end
            end
            S_MUL, S_DIV: if (last) state_n = S_DONE;
            S_DONE:       state_n = S_IDLE;
            default:      state_n = S_IDLE;
        endcase
    end

    // State register with registered busy/done derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n != S_IDLE);
            done  <= (state_n == S_DONE);
        end
    end

    // One shift-add multiply step and one restoring divide step
    always_comb begin
        mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], work_lo[WIDTH-1:1]};
        div_sh  = {work_hi, work_lo[WIDTH-1]};
        div_ge  = (div_sh >= {1'b0, opnd});
        div_hi  = div_ge ? WIDTH'(div_sh - {1'b0, opnd}) : div_sh[WIDTH-1:0];
        div_lo  = {work_lo[WIDTH-2:0], div_ge};
    end

    // Result selection on the edge entering DONE
    always_comb begin
        wr    = 1'b0;
        res_n = result;
        hi_n  = result_hi;
        dbz_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (operation)
                        OP_ADD:  begin wr = 1'b1; res_n = a + b; end
                        OP_SUB:  begin wr = 1'b1; res_n = a - b; end
                        OP_MUL:  ;
                        OP_DIV: begin
                            if (b == '0) begin
                                wr    = 1'b1;
                                res_n = '1;
                                hi_n  = a;
                                dbz_n = 1'b1;
                            end
                        end
                        OP_MOVE: begin wr = 1'b1; res_n = a; end
                        OP_SWAP: begin wr = 1'b1; res_n = b; hi_n = a; end
                        default: wr = 1'b1;
                    endcase
                end
            end
            S_MUL: if (last) begin wr = 1'b1; res_n = mul_lo; hi_n = mul_hi; end
            S_DIV: if (last) begin wr = 1'b1; res_n = div_lo; hi_n = div_hi; end
            default: ;
        endcase
    end

    // Operand latch and iteration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            opnd    <= '0;
            work_hi <= '0;
            work_lo <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        work_hi <= '0;
                        if (operation == OP_MUL) begin
                            opnd    <= a;
                            work_lo <= b;
                        end else begin
                            opnd    <= b;
                            work_lo <= a;
                        end
                    end
                end
                S_MUL: begin
                    cnt     <= cnt + CNT_W'(1);
                    work_hi <= mul_hi;
                    work_lo <= mul_lo;
                end
                S_DIV: begin
                    cnt     <= cnt + CNT_W'(1);
                    work_hi <= div_hi;
                    work_lo <= div_lo;
                end
                default: ;
            endcase
        end
    end

    // Visible results, held until the next completion
    always_ff @(posedge clk) begin
        if (rst) begin
            result      <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else if (wr) begin
            result      <= res_n;
            result_hi   <= hi_n;
            div_by_zero <= dbz_n;
        end
    end

`ifdef ALU_FLAGS_EN
    logic carry_n;

    // Carry-out for add, borrow for sub; only single-cycle ops can set it
    always_comb begin
        carry_n = 1'b0;
        if (state == S_IDLE) begin
            case (operation)
                OP_ADD:  carry_n = (WIDTH'(a + b) < a);
                OP_SUB:  carry_n = (a < b);
                default: carry_n = 1'b0;
            endcase
        end
    end

    // Flags follow the result write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else if (wr) begin
            zero_flag  <= (res_n == '0);
            carry_flag <= carry_n;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard testbench for multicycle_alu; honours ALU_FLAGS_EN.
module tb_multicycle_alu;
    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   operation;
    logic [W-1:0] a, b;
    logic [W-1:0] result, result_hi;
    logic         busy, done, div_by_zero;
`ifdef ALU_FLAGS_EN
    logic         zero_flag, carry_flag;
`endif

    multicycle_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .operation(operation),
        .a(a), .b(b), .result(result), .result_hi(result_hi),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
`ifdef ALU_FLAGS_EN
        , .zero_flag(zero_flag), .carry_flag(carry_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         dbz;
        logic         zf;
        logic         cf;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] m_hi  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        logic [31:0] p;
        e.res = m_res; e.hi = m_hi; e.dbz = 1'b0; e.cf = 1'b0; e.lat = 1;
        case (op)
            4'd0: {e.cf, e.res} = {1'b0, x} + {1'b0, y};
            4'd1: begin e.res = x - y; e.cf = (x < y); end
            4'd2: begin p = 32'(x) * 32'(y); e.res = p[15:0]; e.hi = p[31:16]; e.lat = W + 1; end
            4'd3: begin
                if (y == 0) begin e.res = '1; e.hi = x; e.dbz = 1'b1; end
                else begin e.res = x / y; e.hi = x % y; e.lat = W + 1; end
            end
            4'd4: e.res = x;
            4'd5: begin e.res = y; e.hi = x; end
            default: ;
        endcase
        e.zf = (e.res == 0);
        return e;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".result"}, 32'(result), 32'(e.res));
        check({tag, ".result_hi"}, 32'(result_hi), 32'(e.hi));
        check({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(e.dbz));
`ifdef ALU_FLAGS_EN
        check({tag, ".zero_flag"}, 32'(zero_flag), 32'(e.zf));
        check({tag, ".carry_flag"}, 32'(carry_flag), 32'(e.cf));
`endif
    endtask

    // Issue one op, optionally disturbing inputs while busy, then score completion
    task automatic issue(input string tag, input logic [3:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit noise);
        exp_t         e;
        logic [W-1:0] held_res;
        int           n;
        bit           seen;
        @(negedge clk);
        held_res  = result;
        start     = 1'b1; operation = op; a = x; b = y;
        sb.push_back(model(op, x, y));
        m_res = sb[$].res; m_hi = sb[$].hi;
        @(negedge clk);
        start = 1'b0;
        n = 1; seen = 1'b0;
        while (n <= 40 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                check({tag, ".held"}, 32'(result), 32'(held_res));
                if (noise) begin
                    start = 1'($urandom_range(1)); a = W'($urandom); b = W'($urandom);
                    operation = 4'($urandom);
                end
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        check({tag, ".done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, ".latency"}, 32'(n), 32'(e.lat));
            check({tag, ".busy_at_done"}, 32'(busy), 32'd1);
            check_outputs(tag, e);
            @(negedge clk);
            check({tag, ".done_pulse"}, 32'(done), 32'd0);
            check({tag, ".busy_after"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        exp_t z;
        int   ndone;
        logic [3:0] ops [9];
        ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2; ops[3] = 4'd3; ops[4] = 4'd4;
        ops[5] = 4'd5; ops[6] = 4'd15; ops[7] = 4'd7; ops[8] = 4'd3;
        z.res = '0; z.hi = '0; z.dbz = 1'b0; z.zf = 1'b0; z.cf = 1'b0; z.lat = 0;

        rst = 1'b1; start = 1'b0; operation = 4'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check_outputs("reset", z);
        rst = 1'b0;

        issue("add_wrap", 4'd0, 16'hFFFF, 16'h0001, 1'b0);
        issue("mult", 4'd2, 16'h1234, 16'h0100, 1'b1);
        issue("div", 4'd3, 16'd100, 16'd7, 1'b1);
        issue("div0", 4'd3, 16'd100, 16'd0, 1'b0);
        issue("swap", 4'd5, 16'hAAAA, 16'h5555, 1'b0);
        issue("undef", 4'b1001, 16'h1111, 16'h2222, 1'b0);
        issue("nop", 4'b1111, 16'h3333, 16'h4444, 1'b0);
        issue("move", 4'd4, 16'h0000, 16'h4444, 1'b0);

        // Reset abandons an in-flight division
        @(negedge clk);
        start = 1'b1; operation = 4'd3; a = 16'hFFFF; b = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check_outputs("midrst", z);
        rst = 1'b0; m_res = '0; m_hi = '0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst.no_done", 32'(ndone), 32'd0);
        issue("add_after_rst", 4'd0, 16'd2, 16'd3, 1'b0);

        // Back-to-back single-cycle ops with start held high
        @(negedge clk);
        start = 1'b1; operation = 4'd1; a = 16'd5; b = 16'd7;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("b2b.done%0d", i), 32'(done), 32'((i % 2) == 0));
        end
        start = 1'b0;
        m_res = 16'hFFFE;
        check("b2b.result", 32'(result), 32'hFFFE);
`ifdef ALU_FLAGS_EN
        check("b2b.carry_flag", 32'(carry_flag), 32'd1);
`endif

        // Random mix through the scoreboard
        for (int i = 0; i < 30; i++) begin
            logic [3:0]   op;
            logic [W-1:0] x, y;
            op = ops[$urandom_range(8)];
            x  = W'($urandom);
            y  = ($urandom_range(5) == 0) ? '0 : W'($urandom >> $urandom_range(15));
            issue($sformatf("rnd%0d", i), op, x, y, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
